resp_demux1_2: RTL and testbench

- Registered 1:2 demultiplexer with valid/ready handshakes.
- Routes one 32-bit result stream to one of two consumers, port A or port B, chosen by a per-beat select.
- Sel polarity matches the datapath 2:1 mux: sel=1 selects A, sel=0 selects B.
- Sits between the memory response path and its two consumers (fetch and load/store). Each destination has its own small FIFO, so a stalled consumer never blocks beats bound for the other.

---
 rtl/resp_demux1_2_pkg.sv | 16 +
 rtl/resp_demux1_2_fifo.sv | 86 ++++++++
 rtl/resp_demux1_2.sv | 88 ++++++++
 tb/tb_resp_demux1_2.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/resp_demux1_2_pkg.sv
// Shared definitions for the resp_demux1_2 response demultiplexer.
// Holds the default data width, the select encoding and the default
// per-destination FIFO depth.
package resp_demux1_2_pkg;

  // Default payload width of the response stream.
  localparam int DATA_W = 32;

  // Select encoding, matching the datapath 2:1 mux polarity.
  localparam logic SEL_A = 1'b1;
  localparam logic SEL_B = 1'b0;

  // Default number of entries in each destination FIFO.
  localparam int DEMUX_DEPTH_DEFAULT = 2;

endpackage : resp_demux1_2_pkg

// File: rtl/resp_demux1_2_fifo.sv
// resp_fifo: small first-word fall-through FIFO for one demux destination.
// Ports:
//   clk, reset    - rising-edge clock, async active-high reset
//   flush         - synchronous clear of pointers and count (storage kept)
//   push          - write push_data at this edge (ignored when full/flush)
//   push_data     - payload to store
//   pop           - consumer accepts head (ignored when empty/flush)
//   full          - FIFO holds DEPTH entries
//   valid, data   - head present / head payload (mem[rd_ptr])
//   count         - occupancy, 0..DEPTH
module resp_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     valid,
  output logic [WIDTH-1:0]         data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_en_s;
  logic             pop_en_s;

  // Qualify push/pop: flush wins over both, and full/empty block them.
  always_comb begin
    push_en_s = 1'b0;
    pop_en_s  = 1'b0;
    if (flush) begin
      push_en_s = 1'b0;
      pop_en_s  = 1'b0;
    end else begin
      push_en_s = push && (count_r != CNT_FULL);
      pop_en_s  = pop && (count_r != {CNT_W{1'b0}});
    end
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_r    <= '{default: '0};
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (flush) begin
      // Storage is deliberately left intact; only bookkeeping clears.
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_en_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_en_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_en_s, pop_en_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  assign full  = (count_r == CNT_FULL);
  assign valid = (count_r != {CNT_W{1'b0}});
  assign data  = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule : resp_fifo

// File: rtl/resp_demux1_2.sv
// resp_demux1_2: registered 1:2 demultiplexer with valid/ready handshakes.
// Routes each input beat to port A (in_sel=1) or port B (in_sel=0), each
// backed by its own FIFO so a stalled consumer never blocks the other.
// Ports:
//   clk, reset                 - clock, async active-high reset
//   flush                      - synchronous clear of both FIFOs
//   in_valid/in_ready/in_sel/in_data - input handshake, select, payload
//   outa_valid/outa_ready/outa_data  - port A head handshake and payload
//   outb_valid/outb_ready/outb_data  - port B head handshake and payload
//   a_count, b_count           - per-destination occupancy
module resp_demux1_2
  import resp_demux1_2_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = DEMUX_DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sel,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   outa_valid,
  input  logic                   outa_ready,
  output logic [WIDTH-1:0]       outa_data,
  output logic                   outb_valid,
  input  logic                   outb_ready,
  output logic [WIDTH-1:0]       outb_data,
  output logic [$clog2(DEPTH):0] a_count,
  output logic [$clog2(DEPTH):0] b_count
);

  logic a_full_s;
  logic b_full_s;
  logic sel_full_s;
  logic push_a_s;
  logic push_b_s;

  // Ready follows the selected FIFO's full flag only; a same-cycle pop on a
  // full FIFO does not open it (no bypass), keeping in_ready off the
  // consumer-ready path.
  always_comb begin
    sel_full_s = 1'b0;
    push_a_s   = 1'b0;
    push_b_s   = 1'b0;
    if (in_sel == SEL_A) begin
      sel_full_s = a_full_s;
    end else begin
      sel_full_s = b_full_s;
    end
    in_ready = !flush && !reset && !sel_full_s;
    if (in_valid && in_ready) begin
      push_a_s = (in_sel == SEL_A);
      push_b_s = (in_sel == SEL_B);
    end else begin
      push_a_s = 1'b0;
      push_b_s = 1'b0;
    end
  end

  resp_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (push_a_s),
    .push_data (in_data),
    .pop       (outa_ready),
    .full      (a_full_s),
    .valid     (outa_valid),
    .data      (outa_data),
    .count     (a_count)
  );

  resp_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (push_b_s),
    .push_data (in_data),
    .pop       (outb_ready),
    .full      (b_full_s),
    .valid     (outb_valid),
    .data      (outb_data),
    .count     (b_count)
  );

endmodule : resp_demux1_2

// File: tb/tb_resp_demux1_2.sv
// Scoreboard bench for resp_demux1_2: stimulus tasks queue expected beats
// per port; a negedge monitor compares every presented head against them.
module tb_resp_demux1_2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sel = 1'b0;
  logic [31:0] in_data = 32'h0;
  logic        outa_valid;
  logic        outa_ready = 1'b0;
  logic [31:0] outa_data;
  logic        outb_valid;
  logic        outb_ready = 1'b0;
  logic [31:0] outb_data;
  logic [1:0]  a_count;
  logic [1:0]  b_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];

  resp_demux1_2 #(.WIDTH(32), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
    .outa_valid(outa_valid), .outa_ready(outa_ready), .outa_data(outa_data),
    .outb_valid(outb_valid), .outb_ready(outb_ready), .outb_data(outb_data),
    .a_count(a_count), .b_count(b_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: head must match scoreboard front; pops when consumer ready.
  always @(negedge clk) begin
    if (!reset && !flush) begin
      if (outa_valid) begin
        checks++;
        if (exp_a.size() == 0) begin
          errors++;
          $display("FAIL a_spurious: got %0h expected no beat", outa_data);
        end else begin
          if (outa_data !== exp_a[0]) begin
            errors++;
            $display("FAIL a_data: got %0h expected %0h", outa_data, exp_a[0]);
          end
          if (outa_ready) void'(exp_a.pop_front());
        end
      end
      if (outb_valid) begin
        checks++;
        if (exp_b.size() == 0) begin
          errors++;
          $display("FAIL b_spurious: got %0h expected no beat", outb_data);
        end else begin
          if (outb_data !== exp_b[0]) begin
            errors++;
            $display("FAIL b_data: got %0h expected %0h", outb_data, exp_b[0]);
          end
          if (outb_ready) void'(exp_b.pop_front());
        end
      end
    end
  end

  // Present one beat, wait (bounded) for acceptance, record expectation.
  task automatic send(input logic sel, input logic [31:0] d);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready 0 expected 1 for %0h", d);
    end else if (sel) begin
      exp_a.push_back(d);
    end else begin
      exp_b.push_back(d);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_left", exp_a.size() + exp_b.size(), 32'd0);
  endtask

  initial begin
    int start;
    // Reset state
    @(negedge clk);
    check("rst_a_valid", outa_valid, 32'd0);
    check("rst_b_valid", outb_valid, 32'd0);
    check("rst_counts", {a_count, b_count}, 32'd0);
    check("rst_in_ready", in_ready, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", in_ready, 32'd1);

    // Routing and latency
    @(posedge clk); #1;
    outa_ready = 1'b1;
    outb_ready = 1'b1;
    send(1'b1, 32'hDEADBEEF);
    check("lat_a_valid", outa_valid, 32'd1);
    send(1'b0, 32'h12345678);
    check("lat_b_valid", outb_valid, 32'd1);
    drain();

    // Backpressure isolation and full-with-pop
    outa_ready = 1'b0;
    send(1'b1, 32'h1);
    send(1'b1, 32'h2);
    check("a_count_full", a_count, 32'd2);
    in_valid = 1'b1; in_sel = 1'b1; in_data = 32'h3;
    @(negedge clk);
    check("full_ready_low", in_ready, 32'd0);
    @(posedge clk); #1;
    send(1'b0, 32'hB0);
    check("a_count_held", a_count, 32'd2);
    outa_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b1; in_data = 32'h3;
    @(negedge clk);
    check("full_pop_ready_low", in_ready, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("after_pop_ready", in_ready, 32'd1);
    check("after_pop_count", a_count, 32'd1);
    exp_a.push_back(32'h3);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // Wrap-around streaming to B
    start = cyc;
    for (int i = 0; i < 10; i++) begin
      send(1'b0, i);
      check("b_count_le1", (b_count <= 2'd1), 32'd1);
    end
    check("stream_cycles", cyc - start, 32'd10);
    drain();

    // Flush
    outa_ready = 1'b0;
    outb_ready = 1'b0;
    send(1'b1, 32'h11);
    send(1'b1, 32'h22);
    send(1'b0, 32'h33);
    check("pre_flush_counts", {a_count, b_count}, 32'b1001);
    flush = 1'b1; outb_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h44;
    @(negedge clk);
    check("flush_ready", in_ready, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    exp_a.delete(); exp_b.delete();
    check("flush_valids", {outa_valid, outb_valid}, 32'd0);
    check("flush_counts", {a_count, b_count}, 32'd0);
    outa_ready = 1'b1;
    send(1'b1, 32'hA5);
    drain();

    // Asynchronous reset mid-transfer
    outa_ready = 1'b0;
    send(1'b1, 32'h77);
    check("pre_rst_count", a_count, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_valid", outa_valid, 32'd0);
    check("async_rst_count", a_count, 32'd0);
    check("async_rst_data", outa_data, 32'd0);
    check("async_rst_ready", in_ready, 32'd0);
    exp_a.delete();
    @(posedge clk); #1 reset = 1'b0;
    outa_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_count", a_count, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_resp_demux1_2
